branch_rs: RTL and testbench
============================

// Module: branch_rs
// PURPOSE
//  Reservation station for branch/jump instructions (BEQ..BGEU, JAL, JALR), directly upstream of the branch execute unit.
//  Buffers dispatched ops until both source operands are available, snooping two CDB ports for operand wake-up.
//  Issues at most one ready op per cycle to the branch unit via a registered, one-cycle issue pulse.
//  Drains on misprediction flush.
// PARAMETERS
//  RS_SIZE  8   number of entries (power of 2, >=2)
//  OP_W     6   opcode width
//  TAG_W    4   ROB tag width
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-low reset
//  rdy          in   1      global ready; 0 = pause (no state change)
//  clear        in   1      misprediction flush
//  disp_en      in   1      dispatch valid
//  disp_op      in   OP_W   opcode
//  disp_v1      in   32     rs1 value (meaningful when disp_q1_busy=0)
//  disp_q1_busy in   1      rs1 waits on a tag
//  disp_q1      in   TAG_W  rs1 producer ROB tag
//  disp_v2/_q2_busy/_q2     rs2, same as rs1
//  disp_imm     in   32     immediate
//  disp_pc      in   32     instruction PC
//  disp_dest    in   TAG_W  destination ROB tag
//  cdb0_valid/_tag/_data in 1/TAG_W/32  ALU broadcast
//  cdb1_valid/_tag/_data in 1/TAG_W/32  LSB broadcast
//  rs_full      out  1      no free entry (combinational from state)
//  iss_en       out  1      issue pulse to branch unit
//  iss_op       out  OP_W   issued opcode
//  iss_reg1     out  32     rs1 value
//  iss_reg2     out  32     rs2 value
//  iss_imm      out  32     immediate
//  iss_pc       out  32     PC
//  iss_dest     out  TAG_W  ROB tag
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all entries invalid; all iss_* = 0; rs_full = 0.
//  - Priority per edge: reset > !rdy (hold all state, iss_en <= 0) > clear > issue/dispatch/wake-up.
//  - clear: all entries invalid, iss_en <= 0; same-cycle dispatch is dropped.
//  - Entry state: busy, op, v1, q1_busy, q1, v2, q2_busy, q2, imm, pc, dest.
//  - Dispatch: when disp_en & !rs_full, write lowest-index free entry.
//    rs_full sampled before this edge's issue (entry freed by issue is not reusable same edge).
//    disp_en while rs_full: ignored; upstream must hold.
//  - Dispatch bypass: if disp_qX_busy and a cdbN_valid with cdbN_tag==disp_qX in the same cycle,
//    store cdbN_data and clear busy.
//  - Wake-up: each edge, every busy entry operand with qX_busy and matching valid CDB tag
//    captures data, qX_busy <= 0. cdb0 wins if both ports match (should not occur).
//  - Ready = busy & !q1_busy & !q2_busy, evaluated on registered state (pre-edge).
//    Entry written or woken at edge t is first issuable at edge t+1.
//  - Issue: lowest-index ready entry copied to iss_* registers at the edge, iss_en <= 1 for exactly one cycle,
//    entry freed. None ready: iss_en <= 0, other iss_* hold last value.
//  - Throughput 1 issue/cycle; latency dispatch->iss_en = 1 cycle with both operands ready.
//  - JAL ops dispatch with both q*_busy=0; JALR uses only rs1 (rs2 dispatched not busy).
//  - Occupancy 0..RS_SIZE; rs_full = &busy.
// TESTING
//  1. Reset then dispatch BEQ v1=5 v2=5 pc=0x100 imm=8 dest=3, operands ready
//     -> next cycle iss_en=1, iss_pc=0x100, iss_dest=3; following cycle iss_en=0.
//  2. Dispatch BNE q1_busy tag=7; two cycles later cdb1 tag=7 data=0x22
//     -> iss_en one cycle after the broadcast, iss_reg1=0x22.
//  3. Dispatch with q2 tag=2 while cdb0 tag=2 data=9 in same cycle (bypass) -> issues next cycle, iss_reg2=9.
//  4. Fill 8 entries all waiting on tag 1 -> rs_full=1; a 9th dispatch is ignored;
//     cdb0 tag=1 -> 8 issues on 8 consecutive cycles in index order; rs_full drops after the first.
//  5. Entries 0..3 busy, assert clear with disp_en=1 -> all invalid, rs_full=0, no iss_en next cycle.
//  6. rdy=0 with a ready entry for 3 cycles -> iss_en=0, state held; rdy=1 -> issues next edge;
//     rst=0 mid-operation -> all outputs zero next edge.

Source files
------------

// File: rtl/branch_rs.sv
// -----------------------------------------------------------------------------
// branch_rs
// Reservation station for branch/jump ops (BEQ..BGEU, JAL, JALR). Holds
// dispatched ops until both source operands are known. Operands are woken by
// snooping two CDB ports. At most one ready op is issued per cycle to the
// branch unit through registered iss_* outputs with a one-cycle iss_en pulse.
//
// Ports
//   clk, rst (sync, active-low), rdy (0 = pause), clear (mispredict flush)
//   disp_*   : dispatch request (op, rs1/rs2 value-or-tag, imm, pc, dest tag)
//   cdb0_*   : ALU broadcast (valid/tag/data)
//   cdb1_*   : LSB broadcast (valid/tag/data)
//   rs_full  : every entry occupied (from registered state only)
//   iss_*    : issued op to branch unit, iss_en high for one cycle per issue
// -----------------------------------------------------------------------------
module branch_rs #(
  parameter int RS_SIZE = 8,
  parameter int OP_W    = 6,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             disp_en,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_v1,
  input  logic             disp_q1_busy,
  input  logic [TAG_W-1:0] disp_q1,
  input  logic [31:0]      disp_v2,
  input  logic             disp_q2_busy,
  input  logic [TAG_W-1:0] disp_q2,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [TAG_W-1:0] disp_dest,
  input  logic             cdb0_valid,
  input  logic [TAG_W-1:0] cdb0_tag,
  input  logic [31:0]      cdb0_data,
  input  logic             cdb1_valid,
  input  logic [TAG_W-1:0] cdb1_tag,
  input  logic [31:0]      cdb1_data,
  output logic             rs_full,
  output logic             iss_en,
  output logic [OP_W-1:0]  iss_op,
  output logic [31:0]      iss_reg1,
  output logic [31:0]      iss_reg2,
  output logic [31:0]      iss_imm,
  output logic [31:0]      iss_pc,
  output logic [TAG_W-1:0] iss_dest
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry storage
  logic [RS_SIZE-1:0] busy_reg;
  logic [RS_SIZE-1:0] q1_busy_reg;
  logic [RS_SIZE-1:0] q2_busy_reg;
  logic [OP_W-1:0]    op_reg   [RS_SIZE];
  logic [31:0]        v1_reg   [RS_SIZE];
  logic [31:0]        v2_reg   [RS_SIZE];
  logic [TAG_W-1:0]   q1_reg   [RS_SIZE];
  logic [TAG_W-1:0]   q2_reg   [RS_SIZE];
  logic [31:0]        imm_reg  [RS_SIZE];
  logic [31:0]        pc_reg   [RS_SIZE];
  logic [TAG_W-1:0]   dest_reg [RS_SIZE];

  // Resolve one operand against both CDB ports. Returns {still_busy, value}.
  // cdb0 is checked first so it wins on a (nominally impossible) double match.
  function automatic logic [32:0] snoop(
    input logic             qb,
    input logic [TAG_W-1:0] q,
    input logic [31:0]      v,
    input logic             c0v,
    input logic [TAG_W-1:0] c0t,
    input logic [31:0]      c0d,
    input logic             c1v,
    input logic [TAG_W-1:0] c1t,
    input logic [31:0]      c1d
  );
    logic [32:0] r;
    r = {qb, v};
    if (qb && c0v && (c0t == q))      r = {1'b0, c0d};
    else if (qb && c1v && (c1t == q)) r = {1'b0, c1d};
    return r;
  endfunction

  logic [RS_SIZE-1:0] ready;
  logic [32:0]        op1_next [RS_SIZE];
  logic [32:0]        op2_next [RS_SIZE];
  logic [32:0]        disp_op1_next;
  logic [32:0]        disp_op2_next;

  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      // Readiness uses pre-edge state, so a same-edge wake-up issues next edge.
      assign ready[gi]    = busy_reg[gi] & ~q1_busy_reg[gi] & ~q2_busy_reg[gi];
      assign op1_next[gi] = snoop(q1_busy_reg[gi], q1_reg[gi], v1_reg[gi],
                                  cdb0_valid, cdb0_tag, cdb0_data,
                                  cdb1_valid, cdb1_tag, cdb1_data);
      assign op2_next[gi] = snoop(q2_busy_reg[gi], q2_reg[gi], v2_reg[gi],
                                  cdb0_valid, cdb0_tag, cdb0_data,
                                  cdb1_valid, cdb1_tag, cdb1_data);
    end
  endgenerate

  // Dispatch bypass: a broadcast in the dispatch cycle is captured directly.
  assign disp_op1_next = snoop(disp_q1_busy, disp_q1, disp_v1,
                               cdb0_valid, cdb0_tag, cdb0_data,
                               cdb1_valid, cdb1_tag, cdb1_data);
  assign disp_op2_next = snoop(disp_q2_busy, disp_q2, disp_v2,
                               cdb0_valid, cdb0_tag, cdb0_data,
                               cdb1_valid, cdb1_tag, cdb1_data);

  assign rs_full = &busy_reg;

  // Lowest-index ready entry (issue) and lowest-index free entry (dispatch).
  logic             iss_found;
  logic [IDX_W-1:0] iss_idx;
  logic [IDX_W-1:0] free_idx;
  logic             disp_we;

  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!busy_reg[i]) free_idx = IDX_W'(i);
    end
  end

  // Fullness is judged before this edge's issue; a slot freed now is not reused now.
  assign disp_we = disp_en & ~rs_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg    <= '0;
      q1_busy_reg <= '0;
      q2_busy_reg <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_reg[i]   <= '0;
        v1_reg[i]   <= '0;
        v2_reg[i]   <= '0;
        q1_reg[i]   <= '0;
        q2_reg[i]   <= '0;
        imm_reg[i]  <= '0;
        pc_reg[i]   <= '0;
        dest_reg[i] <= '0;
      end
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (clear) begin
          busy_reg[i] <= 1'b0;
        end else if (iss_found && (iss_idx == IDX_W'(i))) begin
          busy_reg[i] <= 1'b0;
        end else if (disp_we && (free_idx == IDX_W'(i))) begin
          busy_reg[i]    <= 1'b1;
          op_reg[i]      <= disp_op;
          {q1_busy_reg[i], v1_reg[i]} <= disp_op1_next;
          {q2_busy_reg[i], v2_reg[i]} <= disp_op2_next;
          q1_reg[i]      <= disp_q1;
          q2_reg[i]      <= disp_q2;
          imm_reg[i]     <= disp_imm;
          pc_reg[i]      <= disp_pc;
          dest_reg[i]    <= disp_dest;
        end else if (busy_reg[i]) begin
          {q1_busy_reg[i], v1_reg[i]} <= op1_next[i];
          {q2_busy_reg[i], v2_reg[i]} <= op2_next[i];
        end
      end
    end
  end

  // Issue register: payload holds its last value when nothing issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      iss_en   <= 1'b0;
      iss_op   <= '0;
      iss_reg1 <= '0;
      iss_reg2 <= '0;
      iss_imm  <= '0;
      iss_pc   <= '0;
      iss_dest <= '0;
    end else if (!rdy || clear) begin
      iss_en <= 1'b0;
    end else if (iss_found) begin
      iss_en   <= 1'b1;
      iss_op   <= op_reg[iss_idx];
      iss_reg1 <= v1_reg[iss_idx];
      iss_reg2 <= v2_reg[iss_idx];
      iss_imm  <= imm_reg[iss_idx];
      iss_pc   <= pc_reg[iss_idx];
      iss_dest <= dest_reg[iss_idx];
    end else begin
      iss_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// -----------------------------------------------------------------------------
// tb_branch_rs
// Self-checking bench for branch_rs. Expected issues are queued when stimulus
// is driven and compared by a negedge monitor whenever iss_en is seen.
// -----------------------------------------------------------------------------
module tb_branch_rs;

  localparam int TAG_W = 4;
  localparam int OP_W  = 6;

  logic             clk = 1'b0;
  logic             rst, rdy, clear, disp_en;
  logic [OP_W-1:0]  disp_op;
  logic [31:0]      disp_v1, disp_v2, disp_imm, disp_pc;
  logic             disp_q1_busy, disp_q2_busy;
  logic [TAG_W-1:0] disp_q1, disp_q2, disp_dest;
  logic             cdb0_valid, cdb1_valid;
  logic [TAG_W-1:0] cdb0_tag, cdb1_tag;
  logic [31:0]      cdb0_data, cdb1_data;
  logic             rs_full, iss_en;
  logic [OP_W-1:0]  iss_op;
  logic [31:0]      iss_reg1, iss_reg2, iss_imm, iss_pc;
  logic [TAG_W-1:0] iss_dest;

  branch_rs #(.RS_SIZE(8), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .disp_en(disp_en), .disp_op(disp_op),
    .disp_v1(disp_v1), .disp_q1_busy(disp_q1_busy), .disp_q1(disp_q1),
    .disp_v2(disp_v2), .disp_q2_busy(disp_q2_busy), .disp_q2(disp_q2),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_dest(disp_dest),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .rs_full(rs_full), .iss_en(iss_en), .iss_op(iss_op),
    .iss_reg1(iss_reg1), .iss_reg2(iss_reg2), .iss_imm(iss_imm),
    .iss_pc(iss_pc), .iss_dest(iss_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      r1;
    logic [31:0]      r2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dest;
  } iss_t;

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [31:0]      v1;
    logic             q1b;
    logic [TAG_W-1:0] q1;
    logic [31:0]      v2;
    logic             q2b;
    logic [TAG_W-1:0] q2;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] dest;
    logic             c0v;
    logic [TAG_W-1:0] c0t;
    logic [31:0]      c0d;
    logic             c1v;
    logic [TAG_W-1:0] c1t;
    logic [31:0]      c1d;
    logic [31:0]      exp_r1;
    logic [31:0]      exp_r2;
  } vec_t;

  iss_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every observed issue must match the oldest expected record.
  always @(negedge clk) begin
    if (mon_on && iss_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_issue: got pc 0x%08h dest %0d, expected no issue", iss_pc, iss_dest);
      end else begin
        iss_t e;
        e = exp_q.pop_front();
        $display("issue pc=0x%08h op=%0d r1=0x%08h r2=0x%08h imm=0x%08h dest=%0d",
                 iss_pc, iss_op, iss_reg1, iss_reg2, iss_imm, iss_dest);
        chk("iss_op",   32'(iss_op),   32'(e.op));
        chk("iss_reg1", iss_reg1,      e.r1);
        chk("iss_reg2", iss_reg2,      e.r2);
        chk("iss_imm",  iss_imm,       e.imm);
        chk("iss_pc",   iss_pc,        e.pc);
        chk("iss_dest", 32'(iss_dest), 32'(e.dest));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_en = 1'b0; disp_op = '0;
    disp_v1 = '0; disp_q1_busy = 1'b0; disp_q1 = '0;
    disp_v2 = '0; disp_q2_busy = 1'b0; disp_q2 = '0;
    disp_imm = '0; disp_pc = '0; disp_dest = '0;
    cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
    cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] v1, input logic q1b,
                      input logic [TAG_W-1:0] q1, input logic [31:0] v2, input logic q2b,
                      input logic [TAG_W-1:0] q2, input logic [31:0] imm, input logic [31:0] pc,
                      input logic [TAG_W-1:0] dest);
    disp_en = 1'b1; disp_op = op;
    disp_v1 = v1; disp_q1_busy = q1b; disp_q1 = q1;
    disp_v2 = v2; disp_q2_busy = q2b; disp_q2 = q2;
    disp_imm = imm; disp_pc = pc; disp_dest = dest;
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [TAG_W-1:0] dest);
    iss_t e;
    e.op = op; e.r1 = r1; e.r2 = r2; e.imm = imm; e.pc = pc; e.dest = dest;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    // op, v1, q1b, q1, v2, q2b, q2, imm, pc, dest, cdb0 v/t/d, cdb1 v/t/d, exp r1, exp r2
    vt[0] = '{6'd1, 32'd5, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd8, 32'h100, 4'd3,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd5};
    vt[1] = '{6'd3, 32'hFFFF_FFFF, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'h10, 32'h104, 4'd4,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
    vt[2] = '{6'd2, 32'h11, 1'b0, 4'd0, 32'hDEAD, 1'b1, 4'd2, 32'h20, 32'h108, 4'd5,
              1'b1, 4'd2, 32'd9, 1'b0, 4'd0, 32'd0, 32'h11, 32'd9};
    vt[3] = '{6'd5, 32'hBEEF, 1'b1, 4'd6, 32'h33, 1'b0, 4'd0, 32'h24, 32'h10C, 4'd6,
              1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'h77, 32'h77, 32'h33};
    vt[4] = '{6'd7, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'h400, 32'h110, 4'd7,
              1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0};
    vt[5] = '{6'd8, 32'h2000, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd4, 32'h114, 4'd8,
              1'b1, 4'd9, 32'h55, 1'b1, 4'd9, 32'h66, 32'h2000, 32'd0};

    idle();
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    cyc(); cyc();
    chk("reset_iss_en",  32'(iss_en),  32'd0);
    chk("reset_rs_full", 32'(rs_full), 32'd0);
    chk("reset_iss_pc",  iss_pc,       32'd0);
    chk("reset_iss_reg1", iss_reg1,    32'd0);
    rst = 1'b1;
    mon_on = 1'b1;
    cyc();

    // Table: each op must issue exactly one cycle after the edge that writes it.
    for (int i = 0; i < 6; i++) begin
      disp(vt[i].op, vt[i].v1, vt[i].q1b, vt[i].q1, vt[i].v2, vt[i].q2b, vt[i].q2,
           vt[i].imm, vt[i].pc, vt[i].dest);
      cdb0_valid = vt[i].c0v; cdb0_tag = vt[i].c0t; cdb0_data = vt[i].c0d;
      cdb1_valid = vt[i].c1v; cdb1_tag = vt[i].c1t; cdb1_data = vt[i].c1d;
      push(vt[i].op, vt[i].exp_r1, vt[i].exp_r2, vt[i].imm, vt[i].pc, vt[i].dest);
      cyc();
      idle();
      chk("latency_no_early_issue", 32'(iss_en), 32'd0);
      cyc();
      chk("table_iss_en", 32'(iss_en), 32'd1);
    end
    cyc();
    chk("iss_en_single_pulse", 32'(iss_en), 32'd0);

    // Wake-up through cdb1 two cycles after dispatch; a non-matching tag must not wake.
    disp(6'd2, 32'h0, 1'b1, 4'd7, 32'd3, 1'b0, 4'd0, 32'h40, 32'h200, 4'd9);
    cyc();
    idle();
    cdb0_valid = 1'b1; cdb0_tag = 4'd8; cdb0_data = 32'h99;
    cyc();
    idle();
    chk("wait_no_issue_1", 32'(iss_en), 32'd0);
    cdb1_valid = 1'b1; cdb1_tag = 4'd7; cdb1_data = 32'h22;
    push(6'd2, 32'h22, 32'd3, 32'h40, 32'h200, 4'd9);
    cyc();
    idle();
    chk("wait_no_issue_2", 32'(iss_en), 32'd0);
    cyc();
    chk("wake_iss_en", 32'(iss_en), 32'd1);
    cyc();

    // Fill all 8 entries waiting on tag 1; the 9th dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      chk("fill_not_full", 32'(rs_full), 32'd0);
      disp(6'd4, 32'h0, 1'b1, 4'd1, 32'(i), 1'b0, 4'd0, 32'h50, 32'h300 + 32'(4 * i), 4'(i));
      cyc();
    end
    chk("full_after_8", 32'(rs_full), 32'd1);
    disp(6'd6, 32'h1, 1'b0, 4'd0, 32'h2, 1'b0, 4'd0, 32'h60, 32'h400, 4'd15);
    cyc();
    chk("full_9th_ignored", 32'(rs_full), 32'd1);
    chk("full_no_issue", 32'(iss_en), 32'd0);
    idle();
    cdb0_valid = 1'b1; cdb0_tag = 4'd1; cdb0_data = 32'hAB;
    for (int i = 0; i < 8; i++) push(6'd4, 32'hAB, 32'(i), 32'h50, 32'h300 + 32'(4 * i), 4'(i));
    cyc();
    idle();
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("drain_iss_en", 32'(iss_en), 32'd1);
      if (k == 0) chk("drain_full_drops", 32'(rs_full), 32'd0);
    end
    cyc();
    chk("drain_done", 32'(iss_en), 32'd0);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a simultaneous ready dispatch: nothing survives.
    for (int i = 0; i < 4; i++) begin
      disp(6'd1, 32'h0, 1'b1, 4'd3, 32'h0, 1'b0, 4'd0, 32'h0, 32'h500 + 32'(4 * i), 4'(i));
      cyc();
    end
    disp(6'd1, 32'h1, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h0, 32'h5F0, 4'd12);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    idle();
    chk("clear_rs_full", 32'(rs_full), 32'd0);
    chk("clear_iss_en", 32'(iss_en), 32'd0);
    cyc();
    chk("clear_drop_disp", 32'(iss_en), 32'd0);
    cdb0_valid = 1'b1; cdb0_tag = 4'd3; cdb0_data = 32'h1;
    cyc();
    idle();
    cyc();
    chk("clear_entries_gone", 32'(iss_en), 32'd0);

    // Pause: ready entry held for 3 cycles, paused dispatch ignored.
    disp(6'd3, 32'h61, 1'b0, 4'd0, 32'h62, 1'b0, 4'd0, 32'h64, 32'h600, 4'd10);
    cyc();
    rdy = 1'b0;
    disp(6'd5, 32'h71, 1'b0, 4'd0, 32'h72, 1'b0, 4'd0, 32'h74, 32'h700, 4'd11);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("pause_no_issue", 32'(iss_en), 32'd0);
    end
    idle();
    rdy = 1'b1;
    push(6'd3, 32'h61, 32'h62, 32'h64, 32'h600, 4'd10);
    cyc();
    chk("resume_iss_en", 32'(iss_en), 32'd1);
    cyc();
    chk("resume_single", 32'(iss_en), 32'd0);

    // Reset mid-operation: pending ready entry discarded, outputs zeroed.
    disp(6'd1, 32'h81, 1'b0, 4'd0, 32'h82, 1'b0, 4'd0, 32'h84, 32'h800, 4'd13);
    cyc();
    idle();
    rst = 1'b0;
    cyc();
    chk("midrst_iss_en",   32'(iss_en),   32'd0);
    chk("midrst_iss_pc",   iss_pc,        32'd0);
    chk("midrst_iss_reg1", iss_reg1,      32'd0);
    chk("midrst_iss_dest", 32'(iss_dest), 32'd0);
    chk("midrst_rs_full",  32'(rs_full),  32'd0);
    rst = 1'b1;
    cyc(); cyc();
    chk("midrst_entry_gone", 32'(iss_en), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
